// File: rtl/lift_pkg.sv
// Shared types for the lift scheduler and lift controller.
// The floor index width is derived here so that both blocks agree on it.
package lift_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE = 2'd0,
    SWEEP_UP   = 2'd1,
    SWEEP_DOWN = 2'd2
  } sched_state_t;

  typedef enum logic [1:0] {
    CTRL_IDLE      = 2'd0,
    CTRL_MOVE_UP   = 2'd1,
    CTRL_MOVE_DOWN = 2'd2,
    CTRL_DOOR      = 2'd3
  } ctrl_state_t;

  function automatic int floor_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lift_request_scheduler_if.sv
// Connection between the lift request scheduler, the panel debouncers and the lift controller.
// The slave modport is the scheduler's view of these signals.
interface lift_request_scheduler_if import lift_pkg::*; #(
  parameter int NUM_FLOORS = 4,
  localparam int FLOOR_W = floor_w(NUM_FLOORS)
);
  logic [NUM_FLOORS-1:0] call_btn;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  motor_up;
  logic                  motor_down;
  logic                  door_open;
  logic [FLOOR_W-1:0]    request_floor;
  logic                  request_pending;
  logic [NUM_FLOORS-1:0] pending_calls;
  logic                  dir_up;

  modport master (
    output call_btn, current_floor, motor_up, motor_down, door_open,
    input  request_floor, request_pending, pending_calls, dir_up
  );

  modport slave (
    input  call_btn, current_floor, motor_up, motor_down, door_open,
    output request_floor, request_pending, pending_calls, dir_up
  );
endinterface

// File: rtl/lift_call_finder.sv
// Combinational search over the latched calls: the nearest call above the car,
// the nearest call below it, and whether there is a call at the car's floor.
module lift_call_finder import lift_pkg::*; #(
  parameter int NUM_FLOORS = 4,
  localparam int FLOOR_W = floor_w(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0]    cur_floor_i,
  output logic                  up_hit_o,
  output logic [FLOOR_W-1:0]    up_floor_o,
  output logic                  dn_hit_o,
  output logic [FLOOR_W-1:0]    dn_floor_o,
  output logic                  here_hit_o
);

  // A floor reading past the top counts as above every floor.
  always_comb begin
    up_hit_o   = 1'b0;
    up_floor_o = '0;
    dn_hit_o   = 1'b0;
    dn_floor_o = '0;
    here_hit_o = 1'b0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_i[i] && (i > int'(cur_floor_i))) begin
        up_hit_o   = 1'b1;
        up_floor_o = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_i[i] && (i < int'(cur_floor_i))) begin
        dn_hit_o   = 1'b1;
        dn_floor_o = FLOOR_W'(i);
      end
      if (pending_i[i] && (i == int'(cur_floor_i))) begin
        here_hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lift_request_scheduler.sv
// Latches floor calls and hands the lift controller one target at a time,
// serving calls in SCAN order and reversing only once the car has stopped.
module lift_request_scheduler import lift_pkg::*; #(
  parameter int NUM_FLOORS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  lift_request_scheduler_if.slave  bus_if
);

  localparam int FLOOR_W = floor_w(NUM_FLOORS);

  sched_state_t          state_q, state_d, want;
  logic [NUM_FLOORS-1:0] pending_q, pending_d, clr;
  logic [FLOOR_W-1:0]    req_floor_q, req_floor_d;
  logic                  req_pend_q;
  logic                  dir_up_q, dir_up_d;
  logic                  up_hit, dn_hit, here_hit, moving;
  logic [FLOOR_W-1:0]    up_floor, dn_floor;

  lift_call_finder #(.NUM_FLOORS(NUM_FLOORS)) u_finder (
    .pending_i   (pending_q),
    .cur_floor_i (bus_if.current_floor),
    .up_hit_o    (up_hit),
    .up_floor_o  (up_floor),
    .dn_hit_o    (dn_hit),
    .dn_floor_o  (dn_floor),
    .here_hit_o  (here_hit)
  );

  // A call pressed at the floor whose door is opening is being served now.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      clr[i] = bus_if.door_open && (int'(bus_if.current_floor) == i);
    end
    pending_d = (pending_q | bus_if.call_btn) & ~clr;
  end

  assign moving = bus_if.motor_up | bus_if.motor_down;

  always_comb begin
    want = state_q;
    unique case (state_q)
      SCHED_IDLE: begin
        if (up_hit)      want = SWEEP_UP;
        else if (dn_hit) want = SWEEP_DOWN;
        else             want = SCHED_IDLE;
      end
      SWEEP_UP: begin
        if (up_hit || here_hit) want = SWEEP_UP;
        else if (dn_hit)        want = SWEEP_DOWN;
        else                    want = SCHED_IDLE;
      end
      SWEEP_DOWN: begin
        if (dn_hit || here_hit) want = SWEEP_DOWN;
        else if (up_hit)        want = SWEEP_UP;
        else                    want = SCHED_IDLE;
      end
      default: want = SCHED_IDLE;
    endcase

    // Any change of sweep direction waits until the car is standing still.
    state_d = want;
    if (moving && (((want == SWEEP_UP) && !dir_up_q) || ((want == SWEEP_DOWN) && dir_up_q))) begin
      state_d = state_q;
    end

    dir_up_d = dir_up_q;
    if (state_d == SWEEP_UP)   dir_up_d = 1'b1;
    if (state_d == SWEEP_DOWN) dir_up_d = 1'b0;

    if (here_hit)                               req_floor_d = bus_if.current_floor;
    else if ((state_d == SWEEP_UP) && up_hit)   req_floor_d = up_floor;
    else if ((state_d == SWEEP_DOWN) && dn_hit) req_floor_d = dn_floor;
    else                                        req_floor_d = bus_if.current_floor;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCHED_IDLE;
      pending_q   <= '0;
      req_floor_q <= '0;
      req_pend_q  <= 1'b0;
      dir_up_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      req_floor_q <= req_floor_d;
      req_pend_q  <= |pending_q;
      dir_up_q    <= dir_up_d;
    end
  end

  assign bus_if.request_floor   = req_floor_q;
  assign bus_if.request_pending = req_pend_q;
  assign bus_if.pending_calls   = pending_q;
  assign bus_if.dir_up          = dir_up_q;

endmodule
